// File: rtl/alu_inverse_pkg.sv
// alu_inverse shared definitions: opcodes, FSM states, divide length.
// Optional feature macro: ALU_INVERSE_DIVZERO_EN (divide-by-zero trap).
package alu_inverse_pkg;

  localparam logic [1:0] FN_SUB = 2'b00;
  localparam logic [1:0] FN_DIV = 2'b01;
  localparam logic [1:0] FN_SHR = 2'b10;
  localparam logic [1:0] FN_UNP = 2'b11;

  localparam int DIV_ITERS = 8;
  localparam int CNT_W     = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_inverse_divider.sv
// Restoring 8-by-4 divider, one quotient bit per cycle, MSB first.
// Divisor 0 yields quotient 8'hFF and remainder dividend[3:0].
module alu_inverse_divider
  import alu_inverse_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [7:0] i_dividend,
  input  logic [3:0] i_divisor,
  output logic [7:0] o_quo,
  output logic [3:0] o_rem,
  output logic       o_last
);

  logic [7:0]       r_quo;
  logic [3:0]       r_rem;
  logic [3:0]       r_dvs;
  logic [CNT_W-1:0] r_cnt;

  logic [4:0] w_sh;
  logic       w_ge;
  logic [3:0] w_diff;

  // One restoring step: shift in next dividend bit, trial-subtract.
  always_comb begin
    w_sh   = {r_rem, r_quo[7]};
    w_ge   = (w_sh >= {1'b0, r_dvs});
    w_diff = w_sh[3:0] - r_dvs;
    o_rem  = w_ge ? w_diff : w_sh[3:0];
    o_quo  = {r_quo[6:0], w_ge};
    o_last = (r_cnt == CNT_W'(DIV_ITERS - 1));
  end

  // Iteration registers: load operands, then advance once per step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
      r_cnt <= '0;
    end else if (i_step) begin
      r_quo <= o_quo;
      r_rem <= o_rem;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_inverse.sv
// Accumulator ALU: subtract, iterative divide, shift right, nibble unpack.
// Optional macro ALU_INVERSE_DIVZERO_EN traps divide by zero.
module alu_inverse
  import alu_inverse_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset_b,
  input  logic       Load,
  input  logic [7:0] Value,
  input  logic       Start,
  input  logic [3:0] Data,
  input  logic [1:0] Function,
  output logic [7:0] ALUout,
  output logic [3:0] Remainder,
  output logic       Borrow,
  output logic       Busy,
  output logic       Done,
  output logic       DivZero
);

  state_t     r_state;
  logic [7:0] r_acc;
  logic [3:0] r_rem;
  logic       r_borrow;
  logic       r_busy;
  logic       r_done;

  state_t     w_nstate;
  logic [7:0] w_acc;
  logic [3:0] w_rem;
  logic       w_borrow;
  logic       w_busy;
  logic       w_done;
  logic       w_dz;
  logic       w_div_load;

  logic [7:0] w_quo;
  logic [3:0] w_drem;
  logic       w_last;

`ifdef ALU_INVERSE_DIVZERO_EN
  logic r_dz;
  assign DivZero = r_dz;
`else
  assign DivZero = 1'b0;
`endif

  alu_inverse_divider u_div (
    .i_clk      (Clock),
    .i_rst      (Reset_b),
    .i_load     (w_div_load),
    .i_step     (r_state == S_DIV),
    .i_dividend (r_acc),
    .i_divisor  (Data),
    .o_quo      (w_quo),
    .o_rem      (w_drem),
    .o_last     (w_last)
  );

  // Next state and next values of the accumulator and flags.
  always_comb begin
    w_nstate   = r_state;
    w_acc      = r_acc;
    w_rem      = r_rem;
    w_borrow   = r_borrow;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_div_load = 1'b0;
`ifdef ALU_INVERSE_DIVZERO_EN
    w_dz       = r_dz;
`else
    w_dz       = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (Load) begin
          w_acc    = Value;
          w_rem    = '0;
          w_borrow = 1'b0;
          w_dz     = 1'b0;
        end else if (Start) begin
          w_dz = 1'b0;
          unique case (Function)
            FN_SUB: begin
              w_acc    = r_acc - {4'h0, Data};
              w_borrow = (r_acc < {4'h0, Data});
              w_done   = 1'b1;
            end
            FN_SHR: begin
              w_acc  = Data[3] ? 8'h00 : (r_acc >> Data[2:0]);
              w_done = 1'b1;
            end
            FN_UNP: begin
              w_acc  = {4'h0, r_acc[7:4]};
              w_rem  = r_acc[3:0];
              w_done = 1'b1;
            end
            FN_DIV: begin
`ifdef ALU_INVERSE_DIVZERO_EN
              if (Data == 4'h0) begin
                w_dz   = 1'b1;
                w_done = 1'b1;
              end else begin
                w_div_load = 1'b1;
                w_busy     = 1'b1;
                w_nstate   = S_DIV;
              end
`else
              w_div_load = 1'b1;
              w_busy     = 1'b1;
              w_nstate   = S_DIV;
`endif
            end
            default: ;
          endcase
        end
      end
      S_DIV: begin
        if (w_last) begin
          w_acc    = w_quo;
          w_rem    = w_drem;
          w_busy   = 1'b0;
          w_done   = 1'b1;
          w_nstate = S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset_b) r_state <= S_IDLE;
    else         r_state <= w_nstate;
  end

  // Accumulator and flag registers.
  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      r_acc    <= '0;
      r_rem    <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_acc    <= w_acc;
      r_rem    <= w_rem;
      r_borrow <= w_borrow;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

`ifdef ALU_INVERSE_DIVZERO_EN
  // Divide-by-zero flag, cleared by the next accepted Start or Load.
  always_ff @(posedge Clock) begin
    if (Reset_b) r_dz <= 1'b0;
    else         r_dz <= w_dz;
  end
`endif

  assign ALUout    = r_acc;
  assign Remainder = r_rem;
  assign Borrow    = r_borrow;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

// File: doc/alu_inverse.md
ALU_INVERSE -- requirements
Module: alu_inverse

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 Clock  in  1  sole clock; all state updates on posedge.
REQ-003 Reset_b  in  1  synchronous, active-high reset (1 = reset), sampled on posedge Clock.
REQ-004 Load  in  1  when idle, writes Value into accumulator.
REQ-005 Value  in  8  load data.
REQ-006 Start  in  1  one-cycle operation request.
REQ-007 Data  in  4  operand B.
REQ-008 Function  in  2  00 subtract, 01 divide, 10 shift right, 11 unpack.
REQ-009 ALUout  out  8  accumulator, registered.
REQ-010 Remainder  out  4  registered secondary result.
REQ-011 Borrow  out  1  registered; set by subtract underflow.
REQ-012 Busy  out  1  high while a divide is in progress.
REQ-013 Done  out  1  one-cycle pulse when a result is written.
REQ-014 DivZero  out  1  divide-by-zero flag.

Function
REQ-015 States: IDLE, DIV; reset enters IDLE.
REQ-016 IDLE: Load=1 has priority over Start; the same edge sets ALUout=Value and clears Remainder and Borrow; no Done.
REQ-017 IDLE with Start=1 and Function 00: ALUout <= ALUout - {0,Data} mod 256; Borrow <= (ALUout < Data); Done=1 next cycle.
REQ-018 Function 10: ALUout <= ALUout >> Data (logical); Data>=8 gives 0; Borrow unchanged; Done=1 next cycle.
REQ-019 Function 11: ALUout <= {4'h0, ALUout[7:4]}; Remainder <= ALUout[3:0]; Done=1 next cycle.
REQ-020 Function 01: the Start edge latches dividend and divisor, sets Busy=1, and enters DIV.
REQ-021 DIV runs 8 restoring-division iterations, one per cycle, MSB first.
REQ-022 The 8th DIV edge writes ALUout=quotient and Remainder=remainder, sets Done=1 and Busy=0, and returns to IDLE; Done is high 8 cycles after the Start edge.
REQ-023 Start and Load while Busy=1 are ignored; Function/Data changes during DIV have no effect.
REQ-024 Done is high for exactly one cycle per accepted Start; Busy never rises for functions 00, 10 and 11.
REQ-025 Start and Load in the same IDLE cycle: only the Load is performed; the Start is dropped.

Reset
REQ-026 On Reset_b=1 at a posedge, ALUout, Remainder, Borrow, Busy, Done and DivZero all go to 0 and state goes to IDLE, regardless of current state.
REQ-027 Reset mid-divide aborts the divide, produces no Done, and leaves no partial result visible.

Configuration
REQ-028 Macro ALU_INVERSE_DIVZERO_EN: when defined, divide with Data=0 does not enter DIV; next cycle DivZero=1 and Done=1, with ALUout and Remainder unchanged.
REQ-029 With the macro defined, DivZero clears on the next accepted Start or Load.
REQ-030 Without the macro, DivZero is tied 0 and Data=0 runs the full 8 cycles, yielding ALUout=8'hFF and Remainder=dividend[3:0].

Structure
REQ-031 Shared package alu_inverse_pkg holds the Function opcode constants, the state enum and the iteration count 8.
REQ-032 One sub-module, alu_inverse_divider, holds the iteration registers and one restoring step per cycle; the top level holds the FSM, accumulator and flags.

Verification
REQ-033 Load 8'h64, then Start with Function 01 and Data 7 -> Busy high 8 cycles, then ALUout=8'h0E, Remainder=4'h2, and a single-cycle Done pulse.
REQ-034 Load 8'h05, then Start with Function 00 and Data 7 -> next cycle ALUout=8'hFE, Borrow=1, Done=1.
REQ-035 Load 8'hB4, then Start with Function 10 and Data 3 -> ALUout=8'h16; a following Start with Function 10 and Data 9 -> ALUout=8'h00.
REQ-036 Load 8'hA7, then Start with Function 11 -> ALUout=8'h0A, Remainder=4'h7.
REQ-037 Load 8'hA7, then Start with Function 01 and Data 0:
- with the macro -> next cycle DivZero=1, ALUout=8'hA7;
- without the macro -> after 8 cycles ALUout=8'hFF, Remainder=4'h7.
REQ-038 Start a divide, then pulse Start and Load on DIV cycle 2 and assert Reset_b on DIV cycle 4 -> both pulses ignored; after the reset edge all outputs are 0, Busy=0, and no Done appears.
